// File: rtl/chip_valve_sequencer_if.sv
// Host-side control and valve-line bundle for the ChIP prep-stage sequencer.
// The master drives run requests; the slave drives the valve lines and status pulses.
interface chip_valve_sequencer_if;
    logic        start;
    logic        abort;
    logic [2:0]  reagent_sel;
    logic [15:0] fill_cycles;
    logic [15:0] mix_steps;
    logic [4:0]  inlet_ctrl;
    logic        prep_inlet_ctrl;
    logic        prep_outlet_ctrl;
    logic [2:0]  pump;
    logic        busy;
    logic        done;
    logic        err;
    logic        aborted;

    modport master (
        output start, abort, reagent_sel, fill_cycles, mix_steps,
        input  inlet_ctrl, prep_inlet_ctrl, prep_outlet_ctrl, pump,
        input  busy, done, err, aborted
    );

    modport slave (
        input  start, abort, reagent_sel, fill_cycles, mix_steps,
        output inlet_ctrl, prep_inlet_ctrl, prep_outlet_ctrl, pump,
        output busy, done, err, aborted
    );
endinterface

// File: rtl/chip_valve_sequencer.sv
// Fill / settle / mix / drain protocol sequencer for the ChIP prep chamber.
// Every output is registered from the next-state decode, so valve lines never glitch.
module chip_valve_sequencer #(
    parameter int PUMP_DIV      = 1000,
    parameter int SETTLE_CYCLES = 500,
    parameter int DRAIN_CYCLES  = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chip_valve_sequencer_if.slave bus
);
    localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV + 1) : 1;
    localparam logic [15:0]      SETTLE_LOAD = 16'(SETTLE_CYCLES);
    localparam logic [15:0]      DRAIN_LOAD  = 16'(DRAIN_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LOAD    = DIV_W'(PUMP_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_SETTLE, S_MIX, S_DRAIN, S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [15:0]      cnt_reg, cnt_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [15:0]      step_reg, step_next;
    logic [2:0]       phase_reg, phase_next;
    logic [2:0]       sel_reg, sel_next;
    logic [15:0]      mix_reg, mix_next;
    logic             err_next, aborted_next;

    logic [4:0] inlet_reg, inlet_next;
    logic       prep_in_reg, prep_out_reg;
    logic [2:0] pump_reg, pump_next;
    logic       busy_reg, done_reg, err_reg, aborted_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        div_next     = div_reg;
        step_next    = step_reg;
        phase_next   = phase_reg;
        sel_next     = sel_reg;
        mix_next     = mix_reg;
        err_next     = 1'b0;
        aborted_next = 1'b0;
        if (state_reg != S_IDLE && bus.abort) begin
            state_next   = S_IDLE;
            aborted_next = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // A start coinciding with abort is dropped silently.
                    if (bus.start && !bus.abort) begin
                        if (bus.reagent_sel <= 3'd4) begin
                            sel_next = bus.reagent_sel;
                            mix_next = bus.mix_steps;
                            if (bus.fill_cycles == 16'd0) begin
                                state_next = S_SETTLE;
                                cnt_next   = SETTLE_LOAD;
                            end else begin
                                state_next = S_FILL;
                                cnt_next   = bus.fill_cycles;
                            end
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (cnt_reg == 16'd1) begin
                        state_next = S_SETTLE;
                        cnt_next   = SETTLE_LOAD;
                    end else begin
                        cnt_next = cnt_reg - 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_reg == 16'd1) begin
                        if (mix_reg == 16'd0) begin
                            state_next = S_DRAIN;
                            cnt_next   = DRAIN_LOAD;
                        end else begin
                            state_next = S_MIX;
                            phase_next = 3'd0;
                            div_next   = DIV_LOAD;
                            step_next  = mix_reg;
                        end
                    end else begin
                        cnt_next = cnt_reg - 16'd1;
                    end
                end
                S_MIX: begin
                    if (div_reg == DIV_ONE) begin
                        if (step_reg == 16'd1) begin
                            state_next = S_DRAIN;
                            cnt_next   = DRAIN_LOAD;
                        end else begin
                            step_next  = step_reg - 16'd1;
                            div_next   = DIV_LOAD;
                            phase_next = (phase_reg == 3'd5) ? 3'd0 : phase_reg + 3'd1;
                        end
                    end else begin
                        div_next = div_reg - DIV_ONE;
                    end
                end
                S_DRAIN: begin
                    if (cnt_reg == 16'd1) begin
                        state_next = S_DONE;
                    end else begin
                        cnt_next = cnt_reg - 16'd1;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_inlet
            assign inlet_next[gi] = (state_next == S_FILL) && (sel_next == 3'(gi));
        end
    endgenerate

    always_comb begin
        pump_next = 3'b000;
        if (state_next == S_MIX) begin
            case (phase_next)
                3'd0:    pump_next = 3'b110;
                3'd1:    pump_next = 3'b100;
                3'd2:    pump_next = 3'b101;
                3'd3:    pump_next = 3'b001;
                3'd4:    pump_next = 3'b011;
                3'd5:    pump_next = 3'b010;
                default: pump_next = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            div_reg      <= '0;
            step_reg     <= '0;
            phase_reg    <= '0;
            sel_reg      <= '0;
            mix_reg      <= '0;
            inlet_reg    <= '0;
            prep_in_reg  <= 1'b0;
            prep_out_reg <= 1'b0;
            pump_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            aborted_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_reg      <= div_next;
            step_reg     <= step_next;
            phase_reg    <= phase_next;
            sel_reg      <= sel_next;
            mix_reg      <= mix_next;
            inlet_reg    <= inlet_next;
            prep_in_reg  <= (state_next == S_FILL);
            prep_out_reg <= (state_next == S_DRAIN);
            pump_reg     <= pump_next;
            busy_reg     <= (state_next != S_IDLE);
            done_reg     <= (state_next == S_DONE);
            err_reg      <= err_next;
            aborted_reg  <= aborted_next;
        end
    end

    assign bus.inlet_ctrl       = inlet_reg;
    assign bus.prep_inlet_ctrl  = prep_in_reg;
    assign bus.prep_outlet_ctrl = prep_out_reg;
    assign bus.pump             = pump_reg;
    assign bus.busy             = busy_reg;
    assign bus.done             = done_reg;
    assign bus.err              = err_reg;
    assign bus.aborted          = aborted_reg;
endmodule

// File: tb/tb_chip_valve_sequencer.sv
// Bench for chip_valve_sequencer: a frame-queue model of the protocol is compared every
// cycle, plus directed runs with hand-computed expectations and randomized runs.
module tb_chip_valve_sequencer;
    localparam int PD = 2;
    localparam int SC = 3;
    localparam int DC = 4;

    typedef logic [13:0] frame_t;  // {inlet[4:0], pin, pout, pump[2:0], busy, done, err, aborted}

    logic clk;
    logic rst_n;
    chip_valve_sequencer_if bus();

    chip_valve_sequencer #(.PUMP_DIV(PD), .SETTLE_CYCLES(SC), .DRAIN_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    frame_t dut_frame;
    assign dut_frame = {bus.inlet_ctrl, bus.prep_inlet_ctrl, bus.prep_outlet_ctrl, bus.pump,
                        bus.busy, bus.done, bus.err, bus.aborted};

    function automatic frame_t mk(input logic [4:0] inl, input logic pi, input logic po,
                                  input logic [2:0] pm, input logic b, input logic d,
                                  input logic e, input logic a);
        return {inl, pi, po, pm, b, d, e, a};
    endfunction

    // ---------------- reference model: the whole run as a list of output frames
    frame_t exp_q[$];
    frame_t exp_frame;

    task automatic build_run(input logic [2:0] sel, input logic [15:0] fill, input logic [15:0] mix);
        logic [2:0] pat [6];
        logic [4:0] onehot;
        pat[0] = 3'b110; pat[1] = 3'b100; pat[2] = 3'b101;
        pat[3] = 3'b001; pat[4] = 3'b011; pat[5] = 3'b010;
        onehot = 5'b00001 << sel;
        for (int i = 0; i < int'(fill); i++) exp_q.push_back(mk(onehot, 1, 0, 3'b000, 1, 0, 0, 0));
        for (int i = 0; i < SC; i++)         exp_q.push_back(mk(5'b0, 0, 0, 3'b000, 1, 0, 0, 0));
        for (int s = 0; s < int'(mix); s++)
            for (int d = 0; d < PD; d++)     exp_q.push_back(mk(5'b0, 0, 0, pat[s % 6], 1, 0, 0, 0));
        for (int i = 0; i < DC; i++)         exp_q.push_back(mk(5'b0, 0, 1, 3'b000, 1, 0, 0, 0));
        exp_q.push_back(mk(5'b0, 0, 0, 3'b000, 1, 1, 0, 0));
    endtask

    initial begin
        exp_frame = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                exp_frame = '0;
            end else if (exp_frame[3]) begin
                if (bus.abort) begin
                    exp_q.delete();
                    exp_frame = mk(5'b0, 0, 0, 3'b000, 0, 0, 0, 1);
                end else begin
                    exp_frame = (exp_q.size() != 0) ? exp_q.pop_front() : frame_t'(0);
                end
            end else if (bus.start && !bus.abort) begin
                if (bus.reagent_sel <= 3'd4) begin
                    build_run(bus.reagent_sel, bus.fill_cycles, bus.mix_steps);
                    exp_frame = exp_q.pop_front();
                end else begin
                    exp_frame = mk(5'b0, 0, 0, 3'b000, 0, 0, 1, 0);
                end
            end else begin
                exp_frame = '0;
            end
        end
    end

    bit cmp_en = 1'b0;
    initial forever begin
        @(negedge clk);
        if (cmp_en) check("frame", 32'(dut_frame), 32'(exp_frame));
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_start(input logic [2:0] sel, input logic [15:0] fill, input logic [15:0] mix);
        bus.reagent_sel = sel;
        bus.fill_cycles = fill;
        bus.mix_steps   = mix;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int len);
        len = 0;
        while (bus.busy && len < budget) begin
            len++;
            tick();
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    int len;
    int n;

    initial begin
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.reagent_sel = '0;
        bus.fill_cycles = '0;
        bus.mix_steps   = '0;
        repeat (3) tick();
        check("reset_frame", 32'(dut_frame), 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Normal run, with a start of a different reagent while busy
        run_start(3'd2, 16'd5, 16'd6);
        check("normal_inlet", 32'(bus.inlet_ctrl), 32'h04);
        check("normal_pin", 32'(bus.prep_inlet_ctrl), 32'd1);
        bus.reagent_sel = 3'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_start_inlet", 32'(bus.inlet_ctrl), 32'h04);
        wait_idle(200, len);
        check("normal_busy_len", 32'(len + 1), 32'd25);
        $display("normal run sel=2 fill=5 mix=6 busy=%0d", len + 1);
        tick();

        // Zero operands
        run_start(3'd4, 16'd0, 16'd0);
        check("zero_inlet", 32'(bus.inlet_ctrl), 32'd0);
        check("zero_busy", 32'(bus.busy), 32'd1);
        wait_idle(200, len);
        check("zero_busy_len", 32'(len), 32'd8);
        $display("zero run sel=4 fill=0 mix=0 busy=%0d", len);
        tick();

        // Invalid select
        run_start(3'd5, 16'd3, 16'd3);
        check("inv_err", 32'(bus.err), 32'd1);
        check("inv_busy", 32'(bus.busy), 32'd0);
        tick();
        check("inv_err_pulse", 32'(bus.err), 32'd0);
        $display("invalid select sel=5 rejected");

        // Abort at the third pump phase, then restart
        run_start(3'd1, 16'd2, 16'd6);
        n = 0;
        while (bus.pump != 3'b101 && n < 100) begin n++; tick(); end
        check("abort_reach_phase3", 32'(bus.pump), 32'h5);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_pulse", 32'(bus.aborted), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_pump", 32'(bus.pump), 32'd0);
        tick();
        check("abort_pulse_end", 32'(bus.aborted), 32'd0);
        run_start(3'd0, 16'd0, 16'd2);
        n = 0;
        while (bus.pump == 3'b000 && n < 100) begin n++; tick(); end
        check("restart_phase0", 32'(bus.pump), 32'h6);
        wait_idle(200, len);
        $display("abort mid-mix then restart sel=0 fill=0 mix=2");
        tick();

        // Asynchronous reset during FILL
        run_start(3'd3, 16'd10, 16'd1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check("async_rst_frame", 32'(dut_frame), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_start(3'd0, 16'd3, 16'd1);
        check("post_rst_inlet", 32'(bus.inlet_ctrl), 32'h01);
        wait_idle(200, len);
        check("post_rst_busy_len", 32'(len), 32'd13);
        $display("reset during fill, then run sel=0 fill=3 mix=1 busy=%0d", len);
        tick();

        // Randomized runs with spurious starts and aborts
        for (int it = 0; it < 30; it++) begin
            logic [2:0]  sel;
            logic [15:0] fill, mix;
            sel  = 3'($urandom_range(0, 6));
            fill = 16'($urandom_range(0, 12));
            mix  = 16'($urandom_range(0, 8));
            bus.abort = ($urandom_range(0, 9) == 0);
            run_start(sel, fill, mix);
            bus.abort = 1'b0;
            n = 0;
            while (bus.busy && n < 400) begin
                bus.abort = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 14) == 0) begin
                    bus.start       = 1'b1;
                    bus.reagent_sel = 3'($urandom_range(0, 7));
                end
                n++;
                tick();
                bus.abort = 1'b0;
                bus.start = 1'b0;
            end
            check("rand_idle_timeout", 32'(bus.busy), 32'd0);
            $display("random run %0d sel=%0d fill=%0d mix=%0d cycles=%0d", it, sel, fill, mix, n);
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
